// File: rtl/conv3x3_mac.sv
// Multi-channel 3x3 convolution MAC: walks n_ch weight words and activation
// windows, accumulates, and emits one saturated fixed-point result.
module conv3x3_mac #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 144,
    parameter int TAPS       = 9,
    parameter int WW         = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC       = 12,
    parameter int CH_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CH_WIDTH-1:0]   n_ch,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    input  logic [DATA_WIDTH-1:0] wt_q,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [DATA_WIDTH-1:0] act_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WW-1:0]         out_data,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT_ACT, MAC, OUT} state_t;

    localparam int PW = 2 * WW;
    localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(2 ** (WW - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SMIN = -ACC_WIDTH'(2 ** (WW - 1));

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        base_q;
    logic [CH_WIDTH-1:0]          nch_q;
    logic [CH_WIDTH-1:0]          ch;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PW-1:0]         prod [TAPS];
    logic signed [ACC_WIDTH-1:0]  psum;
    logic signed [ACC_WIDTH-1:0]  acc_nx;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [WW-1:0]                sat;

    always_comb begin
        psum = '0;
        for (int i = 0; i < TAPS; i++) begin
            psum = psum + {{(ACC_WIDTH-PW){prod[i][PW-1]}}, prod[i]};
        end
        acc_nx  = acc + psum;
        shifted = acc_nx >>> FRAC;
        if (shifted > SMAX) begin
            sat = SMAX[WW-1:0];
        end else if (shifted < SMIN) begin
            sat = SMIN[WW-1:0];
        end else begin
            sat = shifted[WW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            nch_q     <= '0;
            ch        <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            wt_addr   <= '0;
            act_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                prod[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && n_ch != '0) begin
                        base_q  <= base_addr;
                        nch_q   <= n_ch;
                        acc     <= '0;
                        ch      <= '0;
                        wt_addr <= base_addr;
                        busy    <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    act_ready <= 1'b1;
                    state     <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (act_valid) begin
                        for (int i = 0; i < TAPS; i++) begin
                            prod[i] <= $signed(wt_q[i*WW +: WW])
                                     * $signed(act_data[i*WW +: WW]);
                        end
                        act_ready <= 1'b0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_nx;
                    if (ch == nch_q - CH_WIDTH'(1)) begin
                        // Result is registered here so it is ready with out_valid
                        out_data  <= sat;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        ch      <= ch + CH_WIDTH'(1);
                        wt_addr <= base_q + ADDR_WIDTH'(ch) + ADDR_WIDTH'(1);
                        state   <= ADDR;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Scoreboard bench for conv3x3_mac: directed pixels, ROM model, act source.
module tb_conv3x3_mac;

    localparam int AW = 11;
    localparam int DW = 144;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    n_ch = '0;
    logic          busy;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_q;
    logic          act_valid = 1'b0;
    logic          act_ready;
    logic [DW-1:0] act_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] out_data;
    logic          done;

    conv3x3_mac dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .n_ch(n_ch), .busy(busy), .wt_addr(wt_addr), .wt_q(wt_q),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [2**AW];
    always @(posedge clk) wt_q <= rom[wt_addr];

    int errors = 0;
    int checks = 0;
    logic [WW-1:0] expq [$];
    logic [DW-1:0] aq [$];
    logic [AW-1:0] addrq [$];
    int hold = 0;
    int nacc = 0;
    int stall_ch = -1;
    int stall_len = 0;
    logic hs_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Activation source: presents queue head, optionally stalls in WAIT_ACT
    always @(negedge clk) begin
        if (hold > 0) begin
            act_valid = 1'b0;
            if (act_ready) hold--;
        end else begin
            act_valid = aq.size() > 0;
            if (act_valid) act_data = aq[0];
        end
    end

    always @(posedge clk) begin
        if (!rst && act_valid && act_ready) begin
            addrq.push_back(wt_addr);
            void'(aq.pop_front());
            nacc++;
            if (nacc == stall_ch) hold = stall_len;
        end
    end

    // Output monitor and done-pulse checker
    always @(negedge clk) begin
        if (hs_prev || done) chk("done_pulse", 32'(done), 32'(hs_prev));
        hs_prev = out_valid && out_ready && !rst;
        if (hs_prev) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h required none", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(expq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_kernel(input logic [DW-1:0] k);
        for (int a = 0; a < 2**AW; a++) rom[a] = k;
    endtask

    task automatic load_acts(input int n, input logic [DW-1:0] w);
        for (int i = 0; i < n; i++) aq.push_back(w);
    endtask

    function automatic logic [DW-1:0] all9(input logic [WW-1:0] t);
        return {9{t}};
    endfunction

    function automatic logic [DW-1:0] tap0(input logic [WW-1:0] t);
        return {128'd0, t};
    endfunction

    task automatic run_pixel(input string name, input logic [AW-1:0] base,
                             input logic [7:0] n, input logic [WW-1:0] exp,
                             input int exp_lat, input int bp);
        int lat;
        int bad;
        logic [WW-1:0] held;
        lat = 0;
        expq.push_back(exp);
        base_addr = base;
        n_ch = n;
        start = 1'b1;
        do begin
            tick();
            start = 1'b0;
            lat++;
        end while (!out_valid && lat < 1000);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid required out_valid", name);
            void'(expq.pop_back());
            return;
        end
        if (exp_lat > 0) chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (bp > 0) begin
            bad = 0;
            held = out_data;
            for (int i = 0; i < bp; i++) begin
                tick();
                if (!out_valid || out_data !== held) bad++;
            end
            chk({name, "_hold_bad_cycles"}, 32'(bad), 32'd0);
            out_ready = 1'b1;
        end
        lat = 0;
        while (busy && lat < 100) begin
            tick();
            lat++;
        end
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outputs",
            {busy, wt_addr, act_ready, out_valid, out_data, done}, 32'd0);
        rst = 1'b0;
        tick();

        n_ch = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("zero_ch_ignored_busy", 32'(busy), 32'd0);

        set_kernel(all9(16'h1000));
        load_acts(1, all9(16'h0010));
        addrq.delete();
        run_pixel("unity", 11'h123, 8'd1, 16'h0090, 4, 0);
        chk("unity_addr", 32'(addrq.size() > 0 ? addrq[0] : '1), 32'h123);

        set_kernel(all9(16'hF000));
        load_acts(1, all9(16'h0001));
        run_pixel("negative", 11'h000, 8'd1, 16'hFFF7, 4, 0);

        set_kernel(tap0(16'h0800));
        load_acts(1, all9(16'h0001));
        run_pixel("floor_pos", 11'h005, 8'd1, 16'h0000, 0, 0);
        load_acts(1, all9(16'hFFFF));
        run_pixel("floor_neg", 11'h005, 8'd1, 16'hFFFF, 0, 0);

        set_kernel(all9(16'h7FFF));
        load_acts(4, all9(16'h7FFF));
        run_pixel("sat_pos", 11'h040, 8'd4, 16'h7FFF, 13, 0);
        load_acts(4, all9(16'h8001));
        run_pixel("sat_neg", 11'h040, 8'd4, 16'h8000, 13, 0);

        nacc = 0;
        stall_ch = 2;
        stall_len = 5;
        load_acts(4, all9(16'h7FFF));
        run_pixel("stall", 11'h040, 8'd4, 16'h7FFF, 18, 0);
        stall_ch = -1;

        set_kernel(all9(16'h1000));
        load_acts(3, all9(16'h0010));
        addrq.delete();
        run_pixel("walk", 11'h7FE, 8'd3, 16'h01B0, 10, 0);
        chk("walk_count", 32'(addrq.size()), 32'd3);
        if (addrq.size() == 3) begin
            chk("walk_a0", 32'(addrq[0]), 32'h7FE);
            chk("walk_a1", 32'(addrq[1]), 32'h7FF);
            chk("walk_a2", 32'(addrq[2]), 32'h000);
        end

        load_acts(1, all9(16'h0010));
        out_ready = 1'b0;
        run_pixel("backpressure", 11'h010, 8'd1, 16'h0090, 4, 10);

        nacc = 0;
        stall_ch = 1;
        stall_len = 100;
        load_acts(2, all9(16'h0010));
        base_addr = 11'h010;
        n_ch = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !(nacc == 1 && act_ready); i++) tick();
        chk("reset_reached_ch1_wait", 32'(nacc == 1 && act_ready), 32'd1);
        rst = 1'b1;
        tick();
        chk("reset_abort_outputs",
            {busy, wt_addr, act_ready, out_valid, out_data, done}, 32'd0);
        rst = 1'b0;
        hold = 0;
        stall_ch = -1;
        nacc = 0;
        aq.delete();
        repeat (3) tick();
        chk("after_abort_no_done", 32'(done), 32'd0);

        load_acts(1, all9(16'h0010));
        run_pixel("post_reset", 11'h020, 8'd1, 16'h0090, 4, 0);

        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
